// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage_if
// Brief    : ID/EX operand-stage bus: decode inputs, forwarding taps, outputs.
// Revision : 1.0
// ============================================================================
interface alu_operand_stage_if #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int STALL_CW = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [REG_AW-1:0]   rs1_addr;
    logic [REG_AW-1:0]   rs2_addr;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm_ext;
    logic [XLEN-1:0]     pc;
    logic [1:0]          alu_src_a;
    logic [1:0]          alu_src_b;
    logic [REG_AW-1:0]   exmem_rd;
    logic                exmem_regwrite;
    logic [XLEN-1:0]     exmem_result;
    logic [REG_AW-1:0]   memwb_rd;
    logic                memwb_regwrite;
    logic [XLEN-1:0]     memwb_result;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     src_a;
    logic [XLEN-1:0]     src_b;
    logic [XLEN-1:0]     store_data;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic [STALL_CW-1:0] stall_cnt;

    modport master (
        output in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, imm_ext, pc,
               alu_src_a, alu_src_b, exmem_rd, exmem_regwrite, exmem_result,
               memwb_rd, memwb_regwrite, memwb_result, flush, out_ready,
        input  in_ready, out_valid, src_a, src_b, store_data, fwd_a, fwd_b,
               stall_cnt
    );

    modport slave (
        input  in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, imm_ext, pc,
               alu_src_a, alu_src_b, exmem_rd, exmem_regwrite, exmem_result,
               memwb_rd, memwb_regwrite, memwb_result, flush, out_ready,
        output in_ready, out_valid, src_a, src_b, store_data, fwd_a, fwd_b,
               stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Brief    : Forwarding resolve + operand select behind a valid/ready register.
// Revision : 1.0
// ============================================================================
module alu_operand_stage #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int STALL_CW = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu_operand_stage_if.slave bus
);
    localparam logic [1:0] c_FWD_RF = 2'b00;
    localparam logic [1:0] c_FWD_WB = 2'b01;
    localparam logic [1:0] c_FWD_EX = 2'b10;

    logic [XLEN-1:0]     r_src_a;
    logic [XLEN-1:0]     r_src_b;
    logic [XLEN-1:0]     r_store_data;
    logic [1:0]          r_fwd_a;
    logic [1:0]          r_fwd_b;
    logic                r_out_valid;
    logic [STALL_CW-1:0] r_stall_cnt;

    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;
    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_src_b;
    logic            w_in_ready;
    logic            w_load;
    logic            w_stall;

    // x0 is hardwired zero, so a write to it must never be forwarded
    wire logic w_ex_ok = bus.exmem_regwrite && (bus.exmem_rd != '0);
    wire logic w_wb_ok = bus.memwb_regwrite && (bus.memwb_rd != '0);

    always_comb begin
        w_rs1_val = bus.rs1_data;
        w_fwd_a   = c_FWD_RF;
        if (w_ex_ok && (bus.exmem_rd == bus.rs1_addr)) begin
            w_rs1_val = bus.exmem_result;
            w_fwd_a   = c_FWD_EX;
        end else if (w_wb_ok && (bus.memwb_rd == bus.rs1_addr)) begin
            w_rs1_val = bus.memwb_result;
            w_fwd_a   = c_FWD_WB;
        end

        w_rs2_val = bus.rs2_data;
        w_fwd_b   = c_FWD_RF;
        if (w_ex_ok && (bus.exmem_rd == bus.rs2_addr)) begin
            w_rs2_val = bus.exmem_result;
            w_fwd_b   = c_FWD_EX;
        end else if (w_wb_ok && (bus.memwb_rd == bus.rs2_addr)) begin
            w_rs2_val = bus.memwb_result;
            w_fwd_b   = c_FWD_WB;
        end
    end

    always_comb begin
        w_src_a = '0;
        case (bus.alu_src_a)
            2'b00:   w_src_a = w_rs1_val;
            2'b01:   w_src_a = bus.pc;
            default: w_src_a = '0;
        endcase

        w_src_b = bus.imm_ext;
        case (bus.alu_src_b)
            2'b00:   w_src_b = w_rs2_val;
            2'b10:   w_src_b = XLEN'(4);
            default: w_src_b = bus.imm_ext;
        endcase
    end

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_load     = bus.in_valid && w_in_ready && !bus.flush;
    assign w_stall    = r_out_valid && !bus.out_ready && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_src_a      <= '0;
            r_src_b      <= '0;
            r_store_data <= '0;
            r_fwd_a      <= c_FWD_RF;
            r_fwd_b      <= c_FWD_RF;
            r_stall_cnt  <= '0;
        end else begin
            if (bus.flush) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid  <= 1'b1;
                r_src_a      <= w_src_a;
                r_src_b      <= w_src_b;
                r_store_data <= w_rs2_val;
                r_fwd_a      <= w_fwd_a;
                r_fwd_b      <= w_fwd_b;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.src_a      = r_src_a;
    assign bus.src_b      = r_src_b;
    assign bus.store_data = r_store_data;
    assign bus.fwd_a      = r_fwd_a;
    assign bus.fwd_b      = r_fwd_b;
    assign bus.stall_cnt  = r_stall_cnt;
endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Parametrised successor to the single-cycle ALU operand-B mux, used in the pipelined core at the ID/EX boundary.
- Selects both ALU operands with wider mode sets:
  - A: register, PC or zero.
  - B: register, immediate or constant 4.
- Resolves EX/MEM and MEM/WB forwarding and registers the result behind a one-entry valid/ready pipeline register.
- Supports flush and a saturating stall counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width of operands and results.
- REG_AW, 5, register address width.
- STALL_CW, 16, stall counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  decode stage presents a valid instruction.
- in_ready  output  1  stage can accept the input this cycle.
- rs1_addr, rs2_addr  input  REG_AW  source register numbers.
- rs1_data, rs2_data  input  XLEN  register file read data.
- imm_ext  input  XLEN  sign-extended immediate.
- pc  input  XLEN  instruction address.
- alu_src_a  input  2  operand A mode: 00 rs1, 01 pc, 10/11 zero.
- alu_src_b  input  2  operand B mode: 00 rs2, 01 imm_ext, 10 constant 4, 11 imm_ext.
- exmem_rd  input  REG_AW  destination register of the EX/MEM stage.
- exmem_regwrite  input  1  EX/MEM stage writes a register.
- exmem_result  input  XLEN  EX/MEM result.
- memwb_rd  input  REG_AW  destination register of the MEM/WB stage.
- memwb_regwrite  input  1  MEM/WB stage writes a register.
- memwb_result  input  XLEN  MEM/WB result.
- flush  input  1  synchronous kill of held and incoming entries.
- out_valid  output  1  registered operands are valid.
- out_ready  input  1  execute stage consumes the output.
- src_a, src_b  output  XLEN  registered ALU operands.
- store_data  output  XLEN  registered forwarded rs2, independent of alu_src_b.
- fwd_a, fwd_b  output  2  registered forwarding source: 00 regfile, 01 MEM/WB, 10 EX/MEM.
- stall_cnt  output  STALL_CW  saturating count of stall cycles.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid, src_a, src_b, store_data, fwd_a, fwd_b and stall_cnt all go to 0 immediately. Holding rst_n low mid-transfer drops the held entry.
- Forwarding is combinational on inputs and evaluated per source (rs1, rs2):
  - Use EX/MEM if exmem_regwrite is set, exmem_rd is nonzero and exmem_rd equals the source address.
  - Else use MEM/WB under the same conditions.
  - Else use regfile data.
  - If both stages match, EX/MEM wins. A destination of x0 never forwards.
- Operand selection applies to the forwarded values:
  - src_a: pc if alu_src_a is 01; zero if alu_src_a is 1x.
  - Constant 4 is zero-extended to XLEN.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, no bubble on back-to-back transfers).
  - load = in_valid && in_ready && !flush.
  - On load: register the operands, store_data and fwd codes; set out_valid to 1.
  - Transfer complete with no load: out_valid goes to 0.
  - Data is held stable while out_valid && !out_ready.
- Latency: 1 cycle from an accepted input to out_valid.
- Flush:
  - Next edge out_valid becomes 0 and the incoming entry is discarded.
  - Flush has priority over load and over the hold condition.
  - Datapath registers may retain stale values.
- Stall counter:
  - Increments when out_valid && !out_ready && !flush.
  - Saturates at all-ones; it never wraps.
  - Cleared only by reset.
- Simultaneous consume and load: the new entry replaces the old one; out_valid stays 1.

Test Plan:
- rs2_data=0x5, imm_ext=0x4, alu_src_b=00 then 01, no forwarding, out_ready=1 → src_b=0x5 then 0x4, each one cycle after acceptance; fwd_b=00.
- rs1_addr=3, exmem_rd=3, exmem_regwrite=1, exmem_result=0x10, memwb_rd=3, memwb_regwrite=1, memwb_result=0x8, alu_src_a=00 → src_a=0x10, fwd_a=10. Then drop exmem_regwrite → src_a=0x8, fwd_a=01.
- exmem_rd=0, exmem_regwrite=1, rs2_addr=0, rs2_data=0 → src_b=0, fwd_b=00. Then alu_src_a=01 with pc=0x100 and alu_src_b=10 → src_a=0x100, src_b=0x4.
- out_ready=0 for 3 cycles with out_valid=1 → in_ready=0, outputs stable, stall_cnt=3. Raise out_ready with in_valid=1 → back-to-back transfer, out_valid stays 1.
- flush=1 while out_valid=1 and in_valid=1 → next cycle out_valid=0 and the input is not captured. Saturation: force STALL_CW=2 with 5 stall cycles → stall_cnt=3.
- Assert rst_n=0 mid-stall, asynchronously between edges → out_valid, outputs and stall_cnt read 0 before the next clock edge.
